// File: rtl/cw_sequencer.sv
// Control-word program sequencer.
// Stores up to DEPTH 16-bit control words from the switches. It then replays them to the
// Datapath, one word per issue, in either single-step mode or free-running mode. An issued
// word is driven for exactly one clock. Every other cycle drives NOP (16'h0000, so RW=0).
//
// Ports:
//   clk          system clock
//   reset_b      asynchronous active-low reset
//   cw_in        control word from switches {DA,AA,BA,MB,FS,MD,RW}
//   load         pulse: append cw_in to the buffer (IDLE only)
//   start        pulse: replay from slot 0 (IDLE or DONE, count > 0)
//   step         pulse: issue next word while waiting in step mode
//   run          level: 1 = free-running, 0 = single-step
//   clear        pulse: empty buffer, return to IDLE (highest priority)
//   control_word registered word to the Datapath
//   cw_valid     high while control_word carries an issued word
//   count        number of words loaded, 0..DEPTH
//   pc           index of the last-issued / next-to-issue slot
//   full         count == DEPTH
//   busy         replay in progress (ISSUE or WAIT)
//   done         replay finished (DONE)
module cw_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned RUN_DIV = 25000000
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic [15:0]   cw_in,
  input  logic          load,
  input  logic          start,
  input  logic          step,
  input  logic          run,
  input  logic          clear,
  output logic [15:0]   control_word,
  output logic          cw_valid,
  output logic [AW:0]   count,
  output logic [AW-1:0] pc,
  output logic          full,
  output logic          busy,
  output logic          done
);

  localparam int unsigned DW       = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DivLast  = DW'(RUN_DIV - 1);
  localparam logic [AW:0]   CountMax = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic [15:0]   cw_q, cw_d;
  logic          valid_q, valid_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] div_q, div_d;
  logic          mem_we;
  logic [15:0]   mem_q [DEPTH];
  logic          full_w;

  assign full_w = (count_q == CountMax);

  always_comb begin
    state_d = state_q;
    cw_d    = 16'h0000;  // NOP unless a word is issued this edge
    valid_d = 1'b0;
    count_d = count_q;
    pc_d    = pc_q;
    div_d   = div_q;
    mem_we  = 1'b0;

    if (clear) begin
      state_d = StIdle;
      count_d = '0;
      pc_d    = '0;
      div_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // start shadows a simultaneous load even when it is itself ignored
          if (start) begin
            if (count_q != '0) begin
              pc_d    = '0;
              cw_d    = mem_q[0];
              valid_d = 1'b1;
              state_d = StIssue;
            end
          end else if (load && (state_q == StIdle) && !full_w) begin
            mem_we  = 1'b1;
            count_d = count_q + (AW + 1)'(1);
          end
        end
        StIssue: begin
          if ({1'b0, pc_q} == count_q - (AW + 1)'(1)) begin
            state_d = StDone;
          end else begin
            pc_d    = pc_q + AW'(1);
            div_d   = '0;
            state_d = StWait;
          end
        end
        StWait: begin
          if (run) begin
            if (div_q == DivLast) begin
              cw_d    = mem_q[pc_q];
              valid_d = 1'b1;
              div_d   = '0;
              state_d = StIssue;
            end else begin
              div_d = div_q + DW'(1);
            end
          end else begin
            // Leaving run mode mid-wait restarts the interval from zero
            div_d = '0;
            if (step) begin
              cw_d    = mem_q[pc_q];
              valid_d = 1'b1;
              state_d = StIssue;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= StIdle;
      cw_q    <= 16'h0000;
      valid_q <= 1'b0;
      count_q <= '0;
      pc_q    <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      valid_q <= valid_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      div_q   <= div_d;
    end
  end

  // Buffer is deliberately not reset; slots beyond count are don't-care
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[count_q[AW-1:0]] <= cw_in;
    end
  end

  assign control_word = cw_q;
  assign cw_valid     = valid_q;
  assign count        = count_q;
  assign pc           = pc_q;
  assign full         = full_w;
  assign busy         = (state_q == StIssue) || (state_q == StWait);
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_cw_sequencer.sv
module tb_cw_sequencer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned AW      = 2;
  localparam int unsigned RUN_DIV = 3;
  localparam int unsigned Spacing = RUN_DIV + 1;

  logic          clk;
  logic          reset_b;
  logic [15:0]   cw_in;
  logic          load, start, step, run, clear;
  logic [15:0]   control_word;
  logic          cw_valid;
  logic [AW:0]   count;
  logic [AW-1:0] pc;
  logic          full, busy, done;

  int checks   = 0;
  int failures = 0;
  logic [15:0] model_q [$];

  cw_sequencer #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .RUN_DIV(RUN_DIV)
  ) dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .cw_in       (cw_in),
    .load        (load),
    .start       (start),
    .step        (step),
    .run         (run),
    .clear       (clear),
    .control_word(control_word),
    .cw_valid    (cw_valid),
    .count       (count),
    .pc          (pc),
    .full        (full),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_cw"}, 32'(control_word), 32'h0);
    check({tag, "_valid"}, 32'(cw_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic load_word(input logic [15:0] w, input bit in_idle);
    cw_in = w;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    if (in_idle && model_q.size() < DEPTH) model_q.push_back(w);
    check("load_count", 32'(count), 32'(model_q.size()));
    check("load_full", 32'(full), 32'(model_q.size() == DEPTH));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_q.delete();
    check("clear_count", 32'(count), 32'h0);
    check("clear_pc", 32'(pc), 32'h0);
    check("clear_done", 32'(done), 32'h0);
    check_quiet("clear");
  endtask

  // Single-step replay: each word appears for one cycle only, after start or a step
  task automatic replay_step();
    int n;
    n = model_q.size();
    run   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("st_w0", 32'(control_word), 32'(model_q[0]));
    check("st_v0", 32'(cw_valid), 32'h1);
    check("st_pc0", 32'(pc), 32'h0);
    for (int i = 1; i < n; i++) begin
      tick();
      check("st_gap_cw", 32'(control_word), 32'h0);
      check("st_gap_v", 32'(cw_valid), 32'h0);
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("st_idle_v", 32'(cw_valid), 32'h0);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      check("st_w", 32'(control_word), 32'(model_q[i]));
      check("st_v", 32'(cw_valid), 32'h1);
      check("st_pc", 32'(pc), 32'(i));
    end
    tick();
    check("st_done", 32'(done), 32'h1);
    check("st_pc_last", 32'(pc), 32'(n - 1));
    check_quiet("st_end");
  endtask

  // Free-running replay: word k appears exactly k*Spacing cycles after word 0
  task automatic replay_run();
    int n;
    n = model_q.size();
    run   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rn_w0", 32'(control_word), 32'(model_q[0]));
    check("rn_v0", 32'(cw_valid), 32'h1);
    for (int off = 1; off <= (n - 1) * int'(Spacing); off++) begin
      step = 1'($urandom_range(0, 1));
      tick();
      if (off % Spacing == 0) begin
        check("rn_w", 32'(control_word), 32'(model_q[off / Spacing]));
        check("rn_v", 32'(cw_valid), 32'h1);
      end else begin
        check("rn_idle_cw", 32'(control_word), 32'h0);
        check("rn_idle_v", 32'(cw_valid), 32'h0);
      end
    end
    step = 1'b0;
    tick();
    check("rn_done", 32'(done), 32'h1);
    check_quiet("rn_end");
    run = 1'b0;
  endtask

  initial begin
    reset_b = 1'b0;
    cw_in   = '0;
    {load, start, step, run, clear} = '0;
    tick();
    tick();
    reset_b = 1'b1;
    tick();
    check("rst_count", 32'(count), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check_quiet("rst");

    // Asynchronous reset while a word is on the bus
    load_word(16'($urandom), 1'b1);
    load_word(16'($urandom), 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("pre_rst_v", 32'(cw_valid), 32'h1);
    #2 reset_b = 1'b0;
    #1;
    model_q.delete();
    check("arst_cw", 32'(control_word), 32'h0);
    check("arst_valid", 32'(cw_valid), 32'h0);
    check("arst_count", 32'(count), 32'h0);
    check("arst_pc", 32'(pc), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    tick();
    reset_b = 1'b1;
    tick();
    check_quiet("post_rst");
    check("post_rst_count", 32'(count), 32'h0);

    // Fill to DEPTH, then one overflow load
    load_word(16'h2405, 1'b1);
    load_word(16'h4A09, 1'b1);
    load_word(16'h6C8D, 1'b1);
    load_word(16'h8001, 1'b1);
    load_word(16'hFFFF, 1'b1);

    replay_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    check("extra_step_v", 32'(cw_valid), 32'h0);
    check("extra_step_done", 32'(done), 32'h1);
    check("extra_step_pc", 32'(pc), 32'h3);
    load_word(16'h1357, 1'b0);

    replay_run();

    // Dropping run mid-wait restarts the interval
    start = 1'b1;
    tick();
    start = 1'b0;
    check("drop_w0", 32'(control_word), 32'(model_q[0]));
    tick();
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    check("drop_hold_v", 32'(cw_valid), 32'h0);
    run = 1'b1;
    tick();
    check("drop_a_v", 32'(cw_valid), 32'h0);
    tick();
    check("drop_b_v", 32'(cw_valid), 32'h0);
    tick();
    check("drop_w1_v", 32'(cw_valid), 32'h1);
    check("drop_w1", 32'(control_word), 32'(model_q[1]));
    run = 1'b0;

    // Abort in WAIT after word 1, then start on an empty buffer
    tick();
    check("abort_busy", 32'(busy), 32'h1);
    do_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_quiet("empty_start");
    check("empty_start_done", 32'(done), 32'h0);
    tick();
    check("empty_start2_v", 32'(cw_valid), 32'h0);

    // Randomized programs in random modes
    for (int r = 0; r < 6; r++) begin
      do_clear();
      repeat ($urandom_range(1, DEPTH + 1)) load_word(16'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) replay_run();
      else replay_step();
    end

    // clear beats start from DONE
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    model_q.delete();
    check("prio_count", 32'(count), 32'h0);
    check("prio_done", 32'(done), 32'h0);
    check_quiet("prio");
    tick();
    check("prio_next_v", 32'(cw_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cw_sequencer.md
Name: cw_sequencer

Overview:
- Control-word program sequencer; sits directly upstream of the Datapath and drives its 16-bit control word in place of direct switch entry.
- Buffers up to DEPTH control words entered from switches.
- Replays them to the Datapath one word per issue, in single-step or free-running mode.
- Each word is presented for exactly one clock; all other cycles output NOP (16'h0000, RW=0, so no register write).

Parameters:
- DEPTH, 16, number of control-word slots.
- AW, 4, pointer width; DEPTH = 2**AW.
- RUN_DIV, 25000000, wait cycles between issues in run mode; minimum 1.

Ports:
- clk  input  1  system clock
- reset_b  input  1  asynchronous active-low reset
- cw_in  input  16  control word from switches; fields DA[15:13] AA[12:10] BA[9:7] MB[6] FS[5:2] MD[1] RW[0]
- load  input  1  one-cycle pulse (debounced): append cw_in to buffer
- start  input  1  one-cycle pulse: begin replay from slot 0
- step  input  1  one-cycle pulse: issue next word in step mode
- run  input  1  level: 1 = free-running, 0 = single-step
- clear  input  1  one-cycle pulse: empty buffer, return to IDLE
- control_word  output  16  word to Datapath; registered
- cw_valid  output  1  high in the cycle control_word carries an issued word
- count  output  AW+1  number of words loaded, 0..DEPTH
- pc  output  AW  index of the last-issued / next-to-issue slot
- full  output  1  count == DEPTH
- busy  output  1  state is ISSUE or WAIT
- done  output  1  state is DONE

Behaviour:
- Reset (reset_b=0, asynchronous):
  - state=IDLE; control_word=0, cw_valid=0, count=0, pc=0.
  - full=0, busy=0, done=0.
  - Buffer contents are not reset; they are invalid while count=0.
- Storage: DEPTH x 16 register array; write on clk edge only.
- Input priority in the same cycle: clear > start > step/load.
- clear (any state): next edge state=IDLE, count=0, pc=0, control_word=0, cw_valid=0. RUN_DIV counter cleared.
- IDLE:
  - load: if count<DEPTH, mem[count]<=cw_in and count++; if full, ignored with no state change.
  - start with count==0: ignored, stay IDLE.
  - start with count>0: pc<=0, control_word<=mem[0], cw_valid<=1, go to ISSUE.
  - Result: word 0 is visible in the cycle after the start edge.
- ISSUE (always exactly one cycle):
  - Next edge: control_word<=0, cw_valid<=0.
  - If pc==count-1, go to DONE.
  - Else pc++, RUN_DIV counter<=0, go to WAIT.
- WAIT, run=0:
  - step pulse: control_word<=mem[pc], cw_valid<=1, go to ISSUE.
  - RUN_DIV counter held at 0.
- WAIT, run=1:
  - Counter increments each cycle; step is ignored.
  - When counter==RUN_DIV-1: issue mem[pc] as above and go to ISSUE.
  - Consecutive cw_valid pulses are therefore RUN_DIV+1 cycles apart.
  - run dropping to 0 mid-wait resets the counter to 0.
- DONE:
  - control_word=0, done=1.
  - start re-runs from slot 0 exactly as in IDLE.
  - clear returns to IDLE.
  - load and step are ignored.
- load outside IDLE is ignored; the buffer is never modified during replay.
- pc never exceeds count-1; no wrap-around.
- Reset mid-issue forces control_word=0 immediately, so the Datapath sees no partial write.
- count is AW+1 bits so that DEPTH is representable.

Test Plan:
- Use DEPTH=4, AW=2, RUN_DIV=3 throughout.
- Reset: reset_b=0 mid-cycle -> all outputs 0 immediately, state IDLE; release -> outputs stay 0.
- Load/full:
  - Loads of 16'h2405, 16'h4A09, 16'h6C8D, 16'h8001 -> count=4, full=1.
  - 5th load 16'hFFFF -> count stays 4; a later replay shows no 16'hFFFF.
- Step mode (run=0):
  - start -> next cycle control_word=16'h2405, cw_valid=1 for exactly one cycle, then 0.
  - Each step -> 16'h4A09, 16'h6C8D, 16'h8001 in order.
  - After the last word -> done=1, busy=0, pc=3.
  - A further step has no effect.
- Run mode (run=1, start):
  - cw_valid pulses at cycles t, t+4, t+8, t+12 carrying the four words.
  - Then done=1.
  - step pulses during the run are ignored.
- Abort:
  - clear while in WAIT after word 1 -> next cycle IDLE, count=0, control_word=0.
  - Subsequent start with count=0 -> remains IDLE, cw_valid stays 0.
- Priority: start and clear in the same cycle from DONE -> IDLE with count=0, no issue.
